umi_fifo_flex_sync: RTL and testbench
=====================================

# umi_fifo_flex_sync

Single-clock UMI packet FIFO with data-width conversion, used between a host-side UMI port and a device port of a different data width. Buffers up to DEPTH packets. When the input is wider than the output, data-carrying packets are split into several narrower UMI packets with correctly adjusted length, addresses and end-of-message flag. In the opposite direction it zero-extends.

## Interface
- IDW, 128: input data width in bits (power of two, ≥8)
- ODW, 32: output data width in bits (power of two, ≥8)
- AW, 64: address width
- CW, 32: command width
- DEPTH, 512: FIFO depth in packets (power of two, ≥2)
- SPLIT, 1: 1 = split wide packets; 0 = forward unchanged (truncate or zero-extend data)
- clk  in  1  single clock; all logic on rising edge
- nreset  in  1  synchronous active-low reset
- bypass  in  1  1 = skip storage; combinational in→out path, splitting still applies
- chaosmode  in  1  1 = pseudo-random stalls on both handshakes
- umi_in_valid / umi_in_ready  in / out  1  input handshake
- umi_in_cmd  in  CW  input command
- umi_in_dstaddr, umi_in_srcaddr  in  AW  input addresses
- umi_in_data  in  IDW  input data
- umi_out_valid / umi_out_ready  out / in  1  output handshake
- umi_out_cmd  out  CW  output command
- umi_out_dstaddr, umi_out_srcaddr  out  AW  output addresses
- umi_out_data  out  ODW  output data
- fifo_full, fifo_empty  out  1  storage status

## Operation
- UMI command fields: opcode[4:0], size[7:5], len[15:8], eom[22]; all other bits are copied unchanged. Bytes = (len+1)<<size.
- Data-carrying opcodes: REQ_WRITE 0x03, REQ_POSTED 0x05, REQ_ATOMIC 0x09, RESP_READ 0x02. All other opcodes are never split.
- Storage: circular buffer of DEPTH entries, each holding {cmd, dstaddr, srcaddr, data[IDW]}. Write and read pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- Push happens when umi_in_valid & umi_in_ready. Pop happens when the last output chunk of the head packet is accepted.
- Split applies when SPLIT=1, IDW>ODW, the opcode is data-carrying, bytes > ODW/8, and (1<<size) ≤ ODW/8.
  - W = (ODW/8)>>size elements per chunk.
  - Chunk k carries min(remaining elements, W). Its len = count−1.
  - Chunk k: dstaddr and srcaddr = original + k·ODW/8.
  - Chunk k data = input data shifted right by k·ODW bits.
  - eom = original eom on the final chunk, 0 on all others.
  - A chunk counter tracks progress within the head entry and resets on pop.
- Packets that are not split are forwarded as one packet. Data is truncated to ODW bits or zero-extended to ODW bits.
- If (1<<size) > ODW/8, the packet is forwarded unsplit with truncated data. Callers must not send such packets.
- bypass=1: umi_out_* is driven from umi_in_*, and umi_in_ready = umi_out_ready on the final chunk. FIFO contents are held.
- chaosmode=1: a 16-bit LFSR (seed 0xACE1, reset value) masks umi_out_valid and umi_in_ready, each low on roughly 25% of cycles. A masked handshake transfers nothing.

## Timing
- While nreset is low, at the next edge: pointers = 0, chunk counter = 0, LFSR = seed.
- Outputs during and after reset: umi_out_valid=0, fifo_empty=1, fifo_full=0, umi_in_ready=0.
- umi_in_ready = nreset & !fifo_full (& chaos mask).
- Latency: a packet pushed at edge N is visible on umi_out_* from edge N (registered storage). First-word latency is 1 cycle.
- One output chunk is accepted per cycle when umi_out_ready=1, so an N-chunk packet takes N cycles minimum.
- umi_out_* hold stable while umi_out_valid & !umi_out_ready.
- Simultaneous push and pop when full: push is refused (ready=0). Simultaneous push and pop when empty: the new entry becomes visible the following cycle.
- Throughput: one push per cycle and one chunk per cycle.
- Reset mid-packet discards all stored packets and partial chunk state.

## Test plan
- Reset: after nreset is released, umi_out_valid=0, fifo_empty=1, fifo_full=0, umi_in_ready=1 from the first post-reset cycle.
- IDW=128/ODW=32, REQ_WRITE size=0 len=15 dst=0x100 src=0x200 eom=1, data bytes 0x00..0x0F → four packets:
  - len=3 each
  - dst 0x100/0x104/0x108/0x10C, src 0x200/0x204/0x208/0x20C
  - data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C
  - eom=0,0,0,1
- REQ_WRITE size=2 len=2 (12 bytes) → three packets, each len=0, addresses +4 per packet, eom only on the last.
- REQ_READ size=0 len=15 → a single unchanged packet; RESP_WRITE likewise.
- IDW=32/ODW=128, RESP_READ data 0xDEADBEEF → out_data = 0x…0000DEADBEEF (zero-extended), all other fields identical, 1-cycle latency.
- Hold umi_out_ready=0 and push DEPTH packets:
  - fifo_full=1 and umi_in_ready=0 at DEPTH entries.
  - Then release umi_out_ready: packets emerge in order, fifo_empty=1 after the last pop.
  - Repeat with chaosmode=1: same ordered output.

Source files
------------

// File: rtl/umi_fifo_flex_sync.sv
// umi_fifo_flex_sync: single-clock UMI packet FIFO with data-width conversion.
// Wide data-carrying packets are split into ODW-sized chunks on the way out.
module umi_fifo_flex_sync #(
   parameter int IDW   = 128,
   parameter int ODW   = 32,
   parameter int AW    = 64,
   parameter int CW    = 32,
   parameter int DEPTH = 512,
   parameter int SPLIT = 1
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          bypass,
   input  logic          chaosmode,
   input  logic          umi_in_valid,
   output logic          umi_in_ready,
   input  logic [CW-1:0] umi_in_cmd,
   input  logic [AW-1:0] umi_in_dstaddr,
   input  logic [AW-1:0] umi_in_srcaddr,
   input  logic [IDW-1:0] umi_in_data,
   output logic          umi_out_valid,
   input  logic          umi_out_ready,
   output logic [CW-1:0] umi_out_cmd,
   output logic [AW-1:0] umi_out_dstaddr,
   output logic [AW-1:0] umi_out_srcaddr,
   output logic [ODW-1:0] umi_out_data,
   output logic          fifo_full,
   output logic          fifo_empty
);
   localparam int AB = $clog2(DEPTH);
   localparam int OB = ODW / 8;
   localparam int MW = IDW > ODW ? IDW : ODW;
   localparam int EW = CW + 2 * AW + IDW;
   localparam bit SPLIT_EN = (SPLIT != 0) && (IDW > ODW);
   localparam logic [15:0] SEED = 16'hACE1;

   logic [EW-1:0]  mem_q [DEPTH];
   logic [AB:0]    wr_q, wr_d, rd_q, rd_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic [CW-1:0]  rd_cmd, h_cmd;
   logic [AW-1:0]  rd_dst, rd_src, h_dst, h_src, off;
   logic [IDW-1:0] rd_data, h_data;
   logic [MW-1:0]  wide;
   logic [31:0]    elems, bytes, w, rem;
   logic [7:0]     len_out;
   logic           h_valid, dc, split, last, out_ok, in_ok, out_fire, push, pop;

   assign {rd_cmd, rd_dst, rd_src, rd_data} = mem_q[rd_q[AB-1:0]];

   always_comb begin
      h_cmd    = bypass ? umi_in_cmd : rd_cmd;
      h_dst    = bypass ? umi_in_dstaddr : rd_dst;
      h_src    = bypass ? umi_in_srcaddr : rd_src;
      h_data   = bypass ? umi_in_data : rd_data;
      fifo_empty = wr_q == rd_q;
      fifo_full  = (wr_q[AB] != rd_q[AB]) && (wr_q[AB-1:0] == rd_q[AB-1:0]);
      h_valid  = bypass ? umi_in_valid : !fifo_empty;
      dc       = h_cmd[4:0] == 5'h03 || h_cmd[4:0] == 5'h05 || h_cmd[4:0] == 5'h09 || h_cmd[4:0] == 5'h02;
      elems    = 32'(h_cmd[15:8]) + 32'd1;
      bytes    = elems << h_cmd[7:5];
      w        = 32'(OB) >> h_cmd[7:5];
      split    = SPLIT_EN && dc && bytes > 32'(OB) && (32'd1 << h_cmd[7:5]) <= 32'(OB);
      // elements still owed by the head packet before this chunk
      rem      = elems - 32'(cnt_q) * w;
      last     = !split || rem <= w;
      len_out  = 8'(last ? rem - 32'd1 : w - 32'd1);
      off      = AW'(32'(cnt_q) * 32'(OB));
      wide     = MW'(h_data) >> (32'(cnt_q) * 32'(ODW));
      umi_out_cmd     = split ? {h_cmd[CW-1:23], h_cmd[22] & last, h_cmd[21:16], len_out, h_cmd[7:0]} : h_cmd;
      umi_out_dstaddr = h_dst + off;
      umi_out_srcaddr = h_src + off;
      umi_out_data    = wide[ODW-1:0];
      out_ok   = !chaosmode || (|lfsr_q[1:0]);
      in_ok    = !chaosmode || (|lfsr_q[3:2]);
      umi_out_valid = nreset & h_valid & out_ok;
      out_fire = umi_out_valid & umi_out_ready;
      umi_in_ready = nreset & (bypass ? umi_out_ready & last & out_ok : !fifo_full & in_ok);
      push     = !bypass & umi_in_valid & umi_in_ready;
      pop      = !bypass & out_fire & last;
      wr_d     = wr_q + {{AB{1'b0}}, push};
      rd_d     = rd_q + {{AB{1'b0}}, pop};
      cnt_d    = out_fire ? (last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         lfsr_q <= SEED;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
      end
   end

   always_ff @(posedge clk)
      if (push) mem_q[wr_q[AB-1:0]] <= {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
endmodule

// File: tb/tb_umi_fifo_flex_sync.sv
// tb_umi_fifo_flex_sync: randomized and directed checks of the UMI width-converting FIFO
// against a byte-offset reference model.
module tb_umi_fifo_flex_sync;
   typedef struct packed {
      logic [31:0]  cmd;
      logic [63:0]  dst;
      logic [63:0]  src;
      logic [127:0] data;
   } pkt_t;

   logic clk = 0, nreset = 0, bypass = 0, chaosmode = 0;
   logic in_valid = 0, in_ready, out_valid, out_ready = 0, full, empty;
   logic [31:0] in_cmd = 0, out_cmd, out_data;
   logic [63:0] in_dst = 0, in_src = 0, out_dst, out_src;
   logic [127:0] in_data = 0;
   logic w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0, w_full, w_empty;
   logic [31:0] w_in_cmd = 0, w_out_cmd, w_in_data = 0;
   logic [63:0] w_in_dst = 0, w_in_src = 0, w_out_dst, w_out_src;
   logic [127:0] w_out_data;
   int vecs = 0, errs = 0;
   pkt_t src_q[$], exp_q[$];

   always #5 clk = ~clk;

   umi_fifo_flex_sync #(.IDW(128), .ODW(32), .AW(64), .CW(32), .DEPTH(8), .SPLIT(1)) u_n (
      .clk(clk), .nreset(nreset), .bypass(bypass), .chaosmode(chaosmode),
      .umi_in_valid(in_valid), .umi_in_ready(in_ready), .umi_in_cmd(in_cmd),
      .umi_in_dstaddr(in_dst), .umi_in_srcaddr(in_src), .umi_in_data(in_data),
      .umi_out_valid(out_valid), .umi_out_ready(out_ready), .umi_out_cmd(out_cmd),
      .umi_out_dstaddr(out_dst), .umi_out_srcaddr(out_src), .umi_out_data(out_data),
      .fifo_full(full), .fifo_empty(empty));

   umi_fifo_flex_sync #(.IDW(32), .ODW(128), .AW(64), .CW(32), .DEPTH(4), .SPLIT(1)) u_w (
      .clk(clk), .nreset(nreset), .bypass(1'b0), .chaosmode(1'b0),
      .umi_in_valid(w_in_valid), .umi_in_ready(w_in_ready), .umi_in_cmd(w_in_cmd),
      .umi_in_dstaddr(w_in_dst), .umi_in_srcaddr(w_in_src), .umi_in_data(w_in_data),
      .umi_out_valid(w_out_valid), .umi_out_ready(w_out_ready), .umi_out_cmd(w_out_cmd),
      .umi_out_dstaddr(w_out_dst), .umi_out_srcaddr(w_out_src), .umi_out_data(w_out_data),
      .fifo_full(w_full), .fifo_empty(w_empty));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic pkt_t mk(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s, input logic [127:0] x);
      return {c, d, s, x};
   endfunction

   // Reference: walk the packet in 4-byte output windows by byte offset.
   function automatic void expand(input pkt_t p);
      int sz = int'(p.cmd[7:5]);
      int bytes = (int'(p.cmd[15:8]) + 1) << sz;
      bit dc = p.cmd[4:0] inside {5'h02, 5'h03, 5'h05, 5'h09};
      pkt_t c;
      if (dc && bytes > 4 && (1 << sz) <= 4) begin
         for (int b = 0; b < bytes; b += 4) begin
            int nb = (bytes - b < 4) ? bytes - b : 4;
            c = p;
            c.cmd[15:8] = 8'((nb >> sz) - 1);
            c.cmd[22] = (b + 4 >= bytes) ? p.cmd[22] : 1'b0;
            c.dst = p.dst + 64'(b);
            c.src = p.src + 64'(b);
            c.data = 128'(32'(p.data >> (8 * b)));
            exp_q.push_back(c);
         end
      end else begin
         c = p;
         c.data = 128'(p.data[31:0]);
         exp_q.push_back(c);
      end
   endfunction

   function automatic pkt_t rand_pkt();
      logic [4:0] ops [7] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h07, 5'h09};
      pkt_t p;
      int sz;
      p.cmd = $urandom;
      p.cmd[4:0] = ops[$urandom_range(6)];
      sz = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
      p.cmd[7:5] = 3'(sz);
      p.cmd[15:8] = 8'($urandom_range((32 >> sz) - 1));
      p.dst = {$urandom, $urandom};
      p.src = {$urandom, $urandom};
      p.data = {$urandom, $urandom, $urandom, $urandom};
      return p;
   endfunction

   task automatic cycle(input int rdy_pct, input int vld_pct);
      @(negedge clk);
      if (src_q.size() > 0 && (in_valid || $urandom_range(99) < vld_pct)) begin
         in_valid = 1;
         {in_cmd, in_dst, in_src, in_data} = src_q[0];
      end else in_valid = 0;
      out_ready = $urandom_range(99) < rdy_pct;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            pkt_t e = exp_q.pop_front();
            chk("cmd", out_cmd, e.cmd);
            chk("dst", out_dst, e.dst);
            chk("src", out_src, e.src);
            chk("data", out_data, e.data);
         end
      end
      if (in_valid && in_ready) expand(src_q.pop_front());
   endtask

   task automatic drain(input int rdy_pct, input int vld_pct);
      int n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
         cycle(rdy_pct, vld_pct);
         n++;
      end
      chk("drain_left", 128'(src_q.size() + exp_q.size()), 0);
   endtask

   task automatic push_all();
      int n = 0;
      while (src_q.size() > 0 && n < 500) begin
         cycle(0, 100);
         n++;
      end
      chk("push_left", 128'(src_q.size()), 0);
   endtask

   task automatic directed(input pkt_t p, input pkt_t e []);
      src_q.push_back(p);
      push_all();
      exp_q.delete();
      foreach (e[i]) exp_q.push_back(e[i]);
      drain(100, 0);
   endtask

   task automatic fill(input bit c);
      chaosmode = c;
      for (int i = 0; i < 8; i++) src_q.push_back(rand_pkt());
      push_all();
      @(negedge clk);
      in_valid = 0;
      #1;
      chk("full_flag", full, 1);
      chk("full_ready", in_ready, 0);
      chk("full_nempty", empty, 0);
      drain(100, 0);
      @(negedge clk);
      #1;
      chk("drained_empty", empty, 1);
      chk("drained_valid", out_valid, 0);
      chaosmode = 0;
   endtask

   localparam logic [127:0] D16 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      nreset = 1;
      #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_empty", empty, 1);
      chk("post_rst_valid", out_valid, 0);

      directed(mk(32'h00400F03, 64'h100, 64'h200, D16), '{
         mk(32'h00000303, 64'h100, 64'h200, 128'h03020100),
         mk(32'h00000303, 64'h104, 64'h204, 128'h07060504),
         mk(32'h00000303, 64'h108, 64'h208, 128'h0B0A0908),
         mk(32'h00400303, 64'h10C, 64'h20C, 128'h0F0E0D0C)});
      directed(mk(32'h00400243, 64'h100, 64'h200, D16), '{
         mk(32'h00000043, 64'h100, 64'h200, 128'h03020100),
         mk(32'h00000043, 64'h104, 64'h204, 128'h07060504),
         mk(32'h00400043, 64'h108, 64'h208, 128'h0B0A0908)});
      directed(mk(32'h00400F01, 64'h100, 64'h200, D16), '{mk(32'h00400F01, 64'h100, 64'h200, 128'h03020100)});
      directed(mk(32'h00400F04, 64'h100, 64'h200, D16), '{mk(32'h00400F04, 64'h100, 64'h200, 128'h03020100)});

      @(negedge clk);
      bypass = 1;
      in_valid = 1;
      {in_cmd, in_dst, in_src, in_data} = mk(32'h00400F03, 64'h100, 64'h200, D16);
      out_ready = 1;
      exp_q.delete();
      expand(mk(32'h00400F03, 64'h100, 64'h200, D16));
      for (int k = 0; k < 4; k++) begin
         pkt_t e;
         #1;
         e = exp_q.pop_front();
         chk("byp_valid", out_valid, 1);
         chk("byp_cmd", out_cmd, e.cmd);
         chk("byp_dst", out_dst, e.dst);
         chk("byp_data", out_data, e.data);
         chk("byp_ready", in_ready, exp_q.size() == 0);
         @(negedge clk);
      end
      in_valid = 0;
      bypass = 0;
      out_ready = 0;
      #1;
      chk("byp_fifo_empty", empty, 1);

      @(negedge clk);
      w_in_valid = 1;
      w_in_cmd = 32'h00400042;
      w_in_dst = 64'h300;
      w_in_src = 64'h400;
      w_in_data = 32'hDEADBEEF;
      #1;
      chk("w_ready", w_in_ready, 1);
      chk("w_pre_valid", w_out_valid, 0);
      @(negedge clk);
      w_in_valid = 0;
      #1;
      chk("w_valid", w_out_valid, 1);
      chk("w_data", w_out_data, 128'hDEADBEEF);
      chk("w_cmd", w_out_cmd, 32'h00400042);
      chk("w_dst", w_out_dst, 64'h300);
      chk("w_src", w_out_src, 64'h400);
      w_out_ready = 1;
      @(negedge clk);
      #1;
      chk("w_empty", w_empty, 1);
      w_out_ready = 0;

      for (int r = 0; r < 4; r++) begin
         chaosmode = r[0];
         for (int i = 0; i < 60; i++) src_q.push_back(rand_pkt());
         drain(70, 70);
      end
      chaosmode = 0;

      fill(0);
      fill(1);

      src_q.push_back(mk(32'h00400F03, 64'h100, 64'h200, D16));
      push_all();
      cycle(100, 0);
      @(negedge clk);
      nreset = 0;
      out_ready = 0;
      @(negedge clk);
      nreset = 1;
      #1;
      chk("midrst_empty", empty, 1);
      chk("midrst_valid", out_valid, 0);
      exp_q.delete();
      src_q.delete();
      src_q.push_back(mk(32'h00400F03, 64'h100, 64'h200, D16));
      drain(100, 100);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: run reached %0t without finishing", $time);
      $fatal(1);
   end
endmodule
